// File: rtl/fft_cap_pkg.sv
// Shared sizes, FSM state type and helpers for the FFT spectrum capture block.
package fft_cap_pkg;

  localparam int FFT_N  = 256;
  localparam int DATA_W = 20;
  localparam int MAG_W  = 16;
  localparam int ADDR_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

  // Two's-complement magnitude; the most negative input maps to 2^(DATA_W-1) exactly.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/spectrum_ram.sv
// Double-buffered magnitude store: 2 banks x 256 bins, bank bit is the address MSB.
module spectrum_ram
  import fft_cap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [MAG_W-1:0]  wr_data,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [MAG_W-1:0]  rd_data
);

  logic [MAG_W-1:0] mem [2*FFT_N];
  logic [MAG_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fft_spectrum_capture.sv
// Captures one FFT output frame of |re|+|im| magnitudes into a ping-pong RAM,
// swapping banks only when a full 256-sample frame has been written.
module fft_spectrum_capture
  import fft_cap_pkg::*;
#(
  parameter int MAG_SHIFT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ED,
  input  logic        RDY,
  input  logic [7:0]  ADDR,
  input  logic [19:0] DOR,
  input  logic [19:0] DOI,
  input  logic [7:0]  RD_ADDR,
  output logic [15:0] RD_DATA,
  output logic        FRAME_VALID,
  output logic        FRAME_DONE,
  output logic        DROP,
  output logic        OVF,
  output logic [7:0]  FRAME_CNT
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_N - 1);

  logic [DATA_W-1:0] part     [2];
  logic [DATA_W-1:0] abs_part [2];
  logic [DATA_W:0]   mag_sum;
  logic [DATA_W:0]   mag_shifted;
  logic              mag_sat;
  logic [MAG_W-1:0]  mag_clip;
  logic              take;

  cap_state_t        state_reg;
  logic [ADDR_W-1:0] count_reg;
  logic              bank_sel_reg;
  logic              we_reg;
  logic              last_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [MAG_W-1:0]  mag_reg;
  logic              frame_valid_reg;
  logic              frame_done_reg;
  logic              drop_reg;
  logic              ovf_reg;
  logic [7:0]        frame_cnt_reg;

  assign part[0] = DOR;
  assign part[1] = DOI;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
      assign abs_part[gi] = abs_val(part[gi]);
    end
  endgenerate

  assign mag_sum     = {1'b0, abs_part[0]} + {1'b0, abs_part[1]};
  assign mag_shifted = mag_sum >> MAG_SHIFT;
  assign mag_sat     = mag_shifted > (DATA_W+1)'({MAG_W{1'b1}});
  assign mag_clip    = mag_sat ? {MAG_W{1'b1}} : mag_shifted[MAG_W-1:0];

  // A sample is taken when it starts a frame or continues one in progress.
  assign take = ED && (RDY || (state_reg == CAPTURE));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      bank_sel_reg    <= 1'b0;
      we_reg          <= 1'b0;
      last_reg        <= 1'b0;
      wr_addr_reg     <= '0;
      mag_reg         <= '0;
      frame_valid_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      drop_reg        <= 1'b0;
      ovf_reg         <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      we_reg         <= take;
      last_reg       <= 1'b0;
      drop_reg       <= 1'b0;
      frame_done_reg <= last_reg;

      if (take) begin
        wr_addr_reg <= ADDR;
        mag_reg     <= mag_clip;
        if (mag_sat) begin
          ovf_reg <= 1'b1;
        end
      end

      if (ED) begin
        unique case (state_reg)
          IDLE: begin
            if (RDY) begin
              state_reg <= CAPTURE;
              count_reg <= 8'd1;
            end
          end
          CAPTURE: begin
            if (RDY) begin
              drop_reg  <= 1'b1;
              count_reg <= 8'd1;
            end else if (count_reg == LAST_IDX) begin
              state_reg <= IDLE;
              count_reg <= '0;
              last_reg  <= 1'b1;
            end else begin
              count_reg <= count_reg + 8'd1;
            end
          end
        endcase
      end

      // The final write lands on this same edge, so the swap exposes a complete bank.
      if (last_reg) begin
        bank_sel_reg    <= ~bank_sel_reg;
        frame_cnt_reg   <= frame_cnt_reg + 8'd1;
        frame_valid_reg <= 1'b1;
      end
    end
  end

  spectrum_ram u_ram (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (we_reg),
    .wr_addr ({~bank_sel_reg, wr_addr_reg}),
    .wr_data (mag_reg),
    .rd_addr ({bank_sel_reg, RD_ADDR}),
    .rd_data (RD_DATA)
  );

  assign FRAME_VALID = frame_valid_reg;
  assign FRAME_DONE  = frame_done_reg;
  assign DROP        = drop_reg;
  assign OVF         = ovf_reg;
  assign FRAME_CNT   = frame_cnt_reg;

endmodule

// File: tb/tb_fft_spectrum_capture.sv
// Randomized bench for fft_spectrum_capture against a frame-level reference model.
module tb_fft_spectrum_capture;

  localparam int MAG_SHIFT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ED;
  logic        RDY;
  logic [7:0]  ADDR;
  logic [19:0] DOR;
  logic [19:0] DOI;
  logic [7:0]  RD_ADDR;
  logic [15:0] RD_DATA;
  logic        FRAME_VALID;
  logic        FRAME_DONE;
  logic        DROP;
  logic        OVF;
  logic [7:0]  FRAME_CNT;

  fft_spectrum_capture #(.MAG_SHIFT(MAG_SHIFT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ED          (ED),
    .RDY         (RDY),
    .ADDR        (ADDR),
    .DOR         (DOR),
    .DOI         (DOI),
    .RD_ADDR     (RD_ADDR),
    .RD_DATA     (RD_DATA),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_DONE  (FRAME_DONE),
    .DROP        (DROP),
    .OVF         (OVF),
    .FRAME_CNT   (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: committed spectrum image, frame being assembled, expected pulses.
  int  img      [256];
  int  cur_img  [256];
  int  pend_img [256];
  int  pend_edge = -1;
  bit  in_frame  = 1'b0;
  int  nsamp     = 0;
  bit  exp_ovf   = 1'b0;
  bit  mvalid    = 1'b0;
  bit  mon_valid = 1'b0;
  int  exp_cnt   = 0;
  int  done_q [$];
  int  drop_q [$];
  bit  mon_en    = 1'b0;

  function automatic int mag_of(input int re, input int im, output bit sat);
    int a;
    int b;
    int s;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    s = (a + b) >>> MAG_SHIFT;
    sat = (s > 65535);
    return sat ? 65535 : s;
  endfunction

  function automatic int rand20();
    return int'($urandom_range(0, 1048575)) - 524288;
  endfunction

  task automatic drive(input bit ed, input bit rdy, input logic [7:0] a,
                       input int re, input int im, input logic [7:0] ra);
    bit chk;
    int exp_rd;
    bit sat;
    int m;
    if (pend_edge >= 0 && pend_edge < cyc + 1) begin
      img = pend_img;
      mvalid = 1'b1;
      pend_edge = -1;
    end
    chk = mvalid;
    exp_rd = img[ra];
    ED = ed; RDY = rdy; ADDR = a; DOR = re[19:0]; DOI = im[19:0]; RD_ADDR = ra;
    @(posedge CLK); #1;
    if (ed && (rdy || in_frame)) begin
      m = mag_of(re, im, sat);
      if (sat) exp_ovf = 1'b1;
      if (rdy) begin
        if (in_frame) drop_q.push_back(cyc);
        in_frame = 1'b1;
        nsamp = 0;
      end
      cur_img[a] = m;
      nsamp++;
      if (nsamp == 256) begin
        in_frame = 1'b0;
        pend_img = cur_img;
        pend_edge = cyc + 1;
        done_q.push_back(cyc + 1);
      end
    end
    if (chk) check("rd_data", 32'(RD_DATA), 32'(exp_rd));
  endtask

  task automatic garbage();
    drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), rand20(), rand20(), 8'($urandom));
  endtask

  task automatic idle_read(input int n);
    for (int k = 0; k < n; k++)
      drive(1'($urandom_range(0, 1)), 1'b0, 8'($urandom), rand20(), rand20(), 8'(k));
  endtask

  // kind 0: ramp DOR=bin*16; kind 1: random permutation and data; kind 2: kind 1 plus one saturating sample.
  task automatic send_frame(input int kind, input bit toggle, input int n);
    int perm [256];
    int re;
    int im;
    int hot;
    int j;
    int t;
    for (int k = 0; k < 256; k++) perm[k] = k;
    if (kind != 0) begin
      for (int k = 255; k > 0; k--) begin
        j = $urandom_range(0, k);
        t = perm[k]; perm[k] = perm[j]; perm[j] = t;
      end
    end
    hot = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      if (toggle) garbage();
      if (kind == 0) begin
        re = perm[i] * 16;
        im = 0;
      end else begin
        re = rand20();
        im = rand20();
      end
      if (kind == 2 && i == hot) begin
        re = -524288;
        im = -524288;
      end
      drive(1'b1, i == 0, 8'(perm[i]), re, im, 8'($urandom));
    end
    $display("frame kind=%0d toggle=%0d samples=%0d sent at cycle %0d", kind, toggle, n, cyc);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    mvalid = 1'b0;
    garbage();
    RST = 1'b1;
    in_frame = 1'b0;
    nsamp = 0;
    pend_edge = -1;
    exp_ovf = 1'b0;
    exp_cnt = 0;
    mon_valid = 1'b0;
    done_q.delete();
    drop_q.delete();
    check("rst_rd_data", 32'(RD_DATA), 32'd0);
    check("rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
    check("rst_frame_valid", 32'(FRAME_VALID), 32'd0);
    check("rst_frame_done", 32'(FRAME_DONE), 32'd0);
    check("rst_drop", 32'(DROP), 32'd0);
    check("rst_ovf", 32'(OVF), 32'd0);
    $display("reset applied at cycle %0d", cyc);
  endtask

  always @(negedge CLK) begin
    bit e_done;
    bit e_drop;
    if (mon_en) begin
      e_done = (done_q.size() > 0) && (done_q[0] == cyc);
      if (e_done) begin
        void'(done_q.pop_front());
        exp_cnt++;
        mon_valid = 1'b1;
      end
      e_drop = (drop_q.size() > 0) && (drop_q[0] == cyc);
      if (e_drop) void'(drop_q.pop_front());
      check("frame_done", 32'(FRAME_DONE), 32'(e_done));
      check("drop", 32'(DROP), 32'(e_drop));
      check("ovf", 32'(OVF), 32'(exp_ovf));
      check("frame_cnt", 32'(FRAME_CNT), 32'(exp_cnt & 255));
      check("frame_valid", 32'(FRAME_VALID), 32'(mon_valid));
    end
  end

  initial begin
    RST = 1'b0; ED = 1'b0; RDY = 1'b0; ADDR = '0; DOR = '0; DOI = '0; RD_ADDR = '0;
    do_reset();
    do_reset();
    mon_en = 1'b1;
    idle_read(4);

    send_frame(0, 1'b0, 256);        // ramp: bin k reads k
    idle_read(258);
    send_frame(2, 1'b0, 256);        // saturating sample sets sticky OVF
    idle_read(258);
    send_frame(1, 1'b0, 100);        // abandoned at sample 100
    send_frame(1, 1'b0, 256);
    idle_read(258);
    send_frame(0, 1'b1, 256);        // ED toggling every cycle
    idle_read(258);
    send_frame(1, 1'b0, 256);        // back-to-back pair
    send_frame(1, 1'b0, 256);
    idle_read(258);
    send_frame(1, 1'b0, 128);        // reset mid-capture
    do_reset();
    send_frame(0, 1'b0, 256);
    idle_read(258);

    for (int r = 0; r < 4; r++) begin
      send_frame(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 256 : int'($urandom_range(1, 255)));
      idle_read(int'($urandom_range(0, 3)));
    end
    send_frame(1, 1'b0, 256);
    idle_read(258);

    check("pending_done", 32'(done_q.size()), 32'd0);
    check("pending_drop", 32'(drop_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
